// File: rtl/count_seq_ctrl.sv
// Sequencing/arbitration controller for a preloadable down-counter: grants one of two
// requesters, loads its preload value, enables counting to zero, then pulses done.
module count_seq_ctrl #(
  parameter int CountWidth = 8
) (
  input  logic                  iClk,
  input  logic                  _iReset,
  input  logic [1:0]            iReq,
  input  logic [CountWidth-1:0] iPreldVal0,
  input  logic [CountWidth-1:0] iPreldVal1,
  input  logic [CountWidth-1:0] iCountValue,
  output logic [1:0]            oGnt,
  output logic                  _oLoad,
  output logic                  _oSet,
  output logic [CountWidth-1:0] oPreldVal,
  output logic                  oCountEn,
  output logic                  oDone,
  output logic                  oBusy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    gnt_idx_q, gnt_idx_d;
  logic                    last_q, last_d;
  logic [CountWidth-1:0]   preld_q, preld_d;
  logic [1:0]              gnt_q, gnt_d;
  logic                    load_q, load_d;
  logic                    set_q, set_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    win;

  // State and registered outputs; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge iClk or posedge _iReset) begin
    if (_iReset) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= 1'b0;
      last_q    <= 1'b1;
      preld_q   <= '0;
      gnt_q     <= 2'b00;
      load_q    <= 1'b0;
      set_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      preld_q   <= preld_d;
      gnt_q     <= gnt_d;
      load_q    <= load_d;
      set_q     <= set_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    preld_d   = preld_q;
    win       = (iReq == 2'b11) ? ~last_q : iReq[1];
    case (state_q)
      ST_IDLE: begin
        if (|iReq) begin
          gnt_idx_d = win;
          last_d    = win;
          preld_d   = win ? iPreldVal1 : iPreldVal0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        // Abort wins over reaching zero in the same cycle.
        if (!iReq[gnt_idx_q])
          state_d = ST_CLEAR;
        else if (iCountValue == '0)
          state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output values are decoded from the next state so they appear registered with it.
  always_comb begin
    gnt_d  = 2'b00;
    load_d = 1'b0;
    set_d  = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_LOAD: begin
        gnt_d  = gnt_idx_d ? 2'b10 : 2'b01;
        load_d = 1'b1;
      end
      ST_RUN:  gnt_d = gnt_idx_d ? 2'b10 : 2'b01;
      ST_DONE: begin
        gnt_d  = gnt_idx_d ? 2'b10 : 2'b01;
        done_d = 1'b1;
      end
      ST_CLEAR: set_d = 1'b1;
      default: ;
    endcase
  end

  assign oCountEn  = (state_q == ST_RUN) && (iCountValue != '0);
  assign oGnt      = gnt_q;
  assign _oLoad    = load_q;
  assign _oSet     = set_q;
  assign oPreldVal = preld_q;
  assign oDone     = done_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural down-counter closing the loop.
module tb_count_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] p0, p1;
  logic [7:0] cnt;
  logic [1:0] gnt;
  logic       load_o, set_o, en_o, done_o, busy_o;
  logic [7:0] preld_o;

  int total = 0;
  int bad   = 0;

  count_seq_ctrl #(.CountWidth(8)) dut (
    .iClk(clk), ._iReset(rst), .iReq(req),
    .iPreldVal0(p0), .iPreldVal1(p1), .iCountValue(cnt),
    .oGnt(gnt), ._oLoad(load_o), ._oSet(set_o), .oPreldVal(preld_o),
    .oCountEn(en_o), .oDone(done_o), .oBusy(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter model: set to 0, load, or decrement.
  initial cnt = 8'd0;
  always @(posedge clk) begin
    if (set_o)       cnt <= 8'd0;
    else if (load_o) cnt <= preld_o;
    else if (en_o)   cnt <= cnt - 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full job from the IDLE cycle: LOAD, P enabled RUN cycles, zero cycle, DONE, IDLE.
  task automatic expect_job(input logic [1:0] g, input logic [7:0] p, input string tag);
    tick();
    chk({tag, "_load_gnt"}, gnt, g);
    chk({tag, "_load"}, load_o, 1'b1);
    chk({tag, "_preld"}, preld_o, p);
    chk({tag, "_load_en"}, en_o, 1'b0);
    for (int i = 0; i < p; i++) begin
      tick();
      chk({tag, "_run_en"}, en_o, 1'b1);
      chk({tag, "_run_gnt"}, gnt, g);
    end
    tick();
    chk({tag, "_zero_en"}, en_o, 1'b0);
    chk({tag, "_zero_done"}, done_o, 1'b0);
    tick();
    chk({tag, "_done"}, done_o, 1'b1);
    chk({tag, "_done_gnt"}, gnt, g);
    tick();
    chk({tag, "_idle_done"}, done_o, 1'b0);
    chk({tag, "_idle_gnt"}, gnt, 2'b00);
    chk({tag, "_idle_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; p0 = 8'd0; p1 = 8'd0;
    tick(); tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_load", load_o, 1'b0);
    chk("rst_preld", preld_o, 8'd0);
    rst = 1'b0;
    tick();

    // Single request with preload 3
    req = 2'b01; p0 = 8'd3;
    expect_job(2'b01, 8'd3, "single");
    req = 2'b00;
    tick();
    chk("single_stay_idle", busy_o, 1'b0);

    // Tie from reset: 01, 10, 01
    rst = 1'b1; #1; rst = 1'b0;
    req = 2'b11; p0 = 8'd2; p1 = 8'd1;
    expect_job(2'b01, 8'd2, "rr1");
    expect_job(2'b10, 8'd1, "rr2");
    expect_job(2'b01, 8'd2, "rr3");
    req = 2'b00;
    tick();
    chk("rr_idle", busy_o, 1'b0);

    // Zero preload on requester 1
    req = 2'b10; p1 = 8'd0;
    expect_job(2'b10, 8'd0, "zero");
    req = 2'b00;
    tick();

    // Abort at count 2 with requester 1 pending
    req = 2'b01; p0 = 8'd4; p1 = 8'd1;
    tick();
    chk("abort_load_gnt", gnt, 2'b01);
    req = 2'b11;
    tick(); tick(); tick();
    chk("abort_cnt2_en", en_o, 1'b1);
    req = 2'b10;
    tick();
    chk("abort_set", set_o, 1'b1);
    chk("abort_gnt0", gnt, 2'b00);
    chk("abort_nodone", done_o, 1'b0);
    chk("abort_en", en_o, 1'b0);
    chk("abort_load", load_o, 1'b0);
    tick();
    chk("abort_idle_set", set_o, 1'b0);
    chk("abort_idle_busy", busy_o, 1'b0);
    expect_job(2'b10, 8'd1, "pend");
    req = 2'b00;
    tick();

    // Abort in the same cycle the count reaches zero
    req = 2'b01; p0 = 8'd2;
    tick();
    chk("simul_load_gnt", gnt, 2'b01);
    tick(); tick(); tick();
    chk("simul_zero_en", en_o, 1'b0);
    req = 2'b00;
    tick();
    chk("simul_set", set_o, 1'b1);
    chk("simul_nodone", done_o, 1'b0);
    tick();
    chk("simul_idle_done", done_o, 1'b0);
    chk("simul_idle_busy", busy_o, 1'b0);

    // Asynchronous reset mid-RUN at count 5
    req = 2'b01; p0 = 8'd8;
    tick(); tick(); tick(); tick(); tick();
    chk("mid_en", en_o, 1'b1);
    chk("mid_busy", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_en", en_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_preld", preld_o, 8'd0);
    chk("mid_rst_done", done_o, 1'b0);
    chk("mid_rst_set", set_o, 1'b0);
    tick();
    req = 2'b00;
    rst = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_gnt", gnt, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
